ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Consumes the per-byte output of the PS/2 receiver stage and turns the raw scan-code stream into key events. It strips the `E0` (extended) and `F0` (break) prefixes, filters keyboard status bytes, and buffers complete make/break events in a small FIFO for the game/control logic. It also keeps a held-key bitmap for the eight movement keys, so consumers can poll key state without tracking events.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO entries; power of two, 2..16.
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `byte_valid` input 1: one-cycle strobe; `byte_data`/`byte_err` valid this cycle.
- `byte_data` input 8: received scan-code byte, data bits only, MSB-first corrected.
- `byte_err` input 1: parity/framing error on this byte.
- `evt_ready` input 1: consumer accepts head event.
- `evt_valid` output 1: FIFO non-empty.
- `evt_code` output 8: head event scan code (prefixes removed).
- `evt_ext` output 1: head event was `E0`-prefixed.
- `evt_break` output 1: head event is a release (`F0` seen).
- `held` output 8: [0]W `1D`, [1]A `1C`, [2]S `1B`, [3]D `23` (non-ext); [4]up `75`, [5]left `6B`, [6]down `72`, [7]right `74` (ext).
- `overflow` output 1: sticky; event dropped because FIFO full.
- `err_count` output 8: saturating count of `byte_err` strobes.

## Operation
- Reset: FSM to IDLE, FIFO empty, `evt_valid`=0, `evt_code`=0, `evt_ext`=0, `evt_break`=0, `held`=0, `overflow`=0, `err_count`=0.
- Bytes are processed only on cycles where `byte_valid`=1. Otherwise the FSM holds.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: `E0`→EXT; `F0`→BRK; `AA`,`FA`,`FE`,`EE`,`00`,`FF`→stay in IDLE, no event; any other byte→emit make (ext=0), stay in IDLE.
  - EXT: `F0`→EXT_BRK; `E0`→stay in EXT; any other byte→emit make (ext=1)→IDLE.
  - BRK: any byte except `E0`/`F0`→emit break (ext=0)→IDLE; `E0` or `F0`→IDLE, no event (malformed).
  - EXT_BRK: any byte except `E0`/`F0`→emit break (ext=1)→IDLE; `E0` or `F0`→IDLE, no event.
- `byte_err`=1 with `byte_valid`=1: the byte is discarded, the FSM goes to IDLE from any state (the partial sequence is abandoned), and `err_count` increments, saturating at 255.
- Emit: write {code, ext, break} into the FIFO.
  - If the FIFO is full and no pop occurs this cycle, the event is dropped and `overflow` is set.
  - If the FIFO is full and a pop occurs in the same cycle, the push succeeds.
- `held`: on any emitted event whose {code, ext} matches a bitmap key, that bit is set on make and cleared on break. The update happens even if the event is dropped by a full FIFO.
  - A code match with the wrong ext value does not update `held`; e.g. non-ext `75` (keypad 8) does not touch `held[4]`.
- FIFO is first-word fall-through: `evt_*` always show the head entry. A pop happens when `evt_valid`&`evt_ready`.
- Popping while empty has no effect. `evt_code`/`evt_ext`/`evt_break` are don't-care while `evt_valid`=0.
- Simultaneous push and pop on an empty FIFO: the pop is ignored and the push lands, so `evt_valid`=1 next cycle.

## Timing
- Latency: a final byte strobed at edge N is visible as the `evt_valid` head at N+1 (if the FIFO was empty). `held` is also updated at N+1.
- Prefix bytes change FSM state at N+1 with no output change.
- Back-to-back `byte_valid` on consecutive cycles must be handled with no loss.
- Pop at edge N: the next entry (or `evt_valid`=0) appears at N+1.
- `overflow` is set at the edge of the dropped push. It clears only on `reset`.
- `reset` mid-sequence (e.g. after `E0 F0`): the next byte is decoded from IDLE.

## Test plan
- Make/break: bytes `1C`, `F0 1C` with `evt_ready`=1 → events {1C,ext0,brk0} then {1C,ext0,brk1}; `held[1]` is 1 after the first event and 0 after the second.
- Extended: `E0 75`, `E0 F0 75` → {75,1,0}, {75,1,1}; `held[4]` toggles 1→0. Non-ext `75` → event {75,0,0} with `held`=0.
- Filtering/error: `AA`, `FA` → no events. `E0` followed by `74` with `byte_err`=1, then `23` → single event {23,0,0}, `err_count`=1, `held[3]`=1.
- Overflow: `evt_ready`=0, six make bytes `15 1D 24 2D 2C 35` with FIFO_DEPTH=4 → first four events retained in order, `overflow`=1, `held[0]`=1. Then with `evt_ready`=1, exactly four pops occur.
- Full push+pop: with the FIFO full and `evt_ready`=1 in the same cycle as a final byte → no drop, `overflow` stays 0, ordering preserved.
- Reset mid-sequence: `E0 F0`, then `reset`, then `6B` → event {6B,0,0}; all outputs were at reset values the cycle after `reset`.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: scan-code byte input and key-event output bundle
interface ps2_key_decoder_if;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_err;
   logic       evt_ready;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_break;
   logic [7:0] held;
   logic       overflow;
   logic [7:0] err_count;
   modport master (
      output byte_valid, byte_data, byte_err, evt_ready,
      input  evt_valid, evt_code, evt_ext, evt_break, held, overflow, err_count
   );
   modport slave (
      input  byte_valid, byte_data, byte_err, evt_ready,
      output evt_valid, evt_code, evt_ext, evt_break, held, overflow, err_count
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: strips E0/F0 prefixes, buffers make/break events in a FWFT FIFO, tracks held movement keys
module ps2_key_decoder #(
   parameter int FIFO_DEPTH = 4
) (
   input logic          clk,
   input logic          reset,
   ps2_key_decoder_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
   state_t        state, state_n;
   logic          emit, emit_ext, emit_brk;
   logic          is_pfx, is_status;
   logic [7:0]    key_hit;
   logic [9:0]    mem [FIFO_DEPTH];
   logic [9:0]    head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, pop, push;
   assign is_pfx    = bus.byte_data == 8'hE0 || bus.byte_data == 8'hF0;
   assign is_status = bus.byte_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
   // prefix-tracking state register
   always_ff @(posedge clk)
      state <= reset ? IDLE : state_n;
   // next state and event emission; an errored byte abandons any partial sequence
   always_comb begin
      state_n  = state;
      emit     = 1'b0;
      emit_ext = 1'b0;
      emit_brk = 1'b0;
      if (bus.byte_valid && bus.byte_err)
         state_n = IDLE;
      else if (bus.byte_valid)
         case (state)
            IDLE: begin
               state_n = bus.byte_data == 8'hE0 ? EXT : bus.byte_data == 8'hF0 ? BRK : IDLE;
               emit    = !is_pfx && !is_status;
            end
            EXT: begin
               state_n  = bus.byte_data == 8'hF0 ? EXT_BRK : bus.byte_data == 8'hE0 ? EXT : IDLE;
               emit     = !is_pfx;
               emit_ext = 1'b1;
            end
            BRK: begin
               state_n  = IDLE;
               emit     = !is_pfx;
               emit_brk = 1'b1;
            end
            default: begin
               state_n  = IDLE;
               emit     = !is_pfx;
               emit_ext = 1'b1;
               emit_brk = 1'b1;
            end
         endcase
   end
   assign key_hit = {8{emit}} & {
      emit_ext  && bus.byte_data == 8'h74,
      emit_ext  && bus.byte_data == 8'h72,
      emit_ext  && bus.byte_data == 8'h6B,
      emit_ext  && bus.byte_data == 8'h75,
      !emit_ext && bus.byte_data == 8'h23,
      !emit_ext && bus.byte_data == 8'h1B,
      !emit_ext && bus.byte_data == 8'h1C,
      !emit_ext && bus.byte_data == 8'h1D
   };
   assign full          = count[AW];
   assign bus.evt_valid = count != '0;
   assign pop           = bus.evt_valid && bus.evt_ready;
   assign push          = emit && (!full || pop);
   assign head          = mem[rd_ptr];
   assign bus.evt_code  = bus.evt_valid ? head[9:2] : 8'h00;
   assign bus.evt_ext   = bus.evt_valid && head[1];
   assign bus.evt_break = bus.evt_valid && head[0];
   // event storage, written at the tail
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {bus.byte_data, emit_ext, emit_brk};
   // FIFO pointers and occupancy
   always_ff @(posedge clk)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   // held bitmap follows every emitted event, sticky overflow, saturating error count
   always_ff @(posedge clk)
      if (reset) begin
         bus.held      <= '0;
         bus.overflow  <= 1'b0;
         bus.err_count <= '0;
      end else begin
         bus.held      <= emit_brk ? bus.held & ~key_hit : bus.held | key_hit;
         bus.overflow  <= bus.overflow || (emit && full && !pop);
         bus.err_count <= bus.err_count + 8'(bus.byte_valid && bus.byte_err && bus.err_count != 8'hFF);
      end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed scan-code stimulus with a queue scoreboard checked by a pop monitor
module tb_ps2_key_decoder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   ps2_key_decoder_if bus();
   ps2_key_decoder #(.FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   logic [9:0] exp_q [$];
   logic [9:0] exp_e;
   int n_cmp = 0;
   int n_bad = 0;
   int n_pops = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk);
      exp_q.push_back({code, ext, brk});
   endtask
   task automatic send(input logic [7:0] b, input logic err = 1'b0);
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      bus.byte_err   = err;
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
      bus.byte_err   = 1'b0;
   endtask
   task automatic check_reset(input string tag);
      chk({tag, " evt_valid"}, 32'(bus.evt_valid), 0);
      chk({tag, " evt_code"}, 32'(bus.evt_code), 0);
      chk({tag, " evt_ext/brk"}, 32'({bus.evt_ext, bus.evt_break}), 0);
      chk({tag, " held"}, 32'(bus.held), 0);
      chk({tag, " overflow"}, 32'(bus.overflow), 0);
      chk({tag, " err_count"}, 32'(bus.err_count), 0);
   endtask
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   // monitor: every pop the DUT performs is matched against the scoreboard head
   always @(negedge clk)
      if (!reset && bus.evt_valid && bus.evt_ready) begin
         n_pops++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: got %0h/%0b/%0b expected none", bus.evt_code, bus.evt_ext, bus.evt_break);
         end else begin
            exp_e = exp_q.pop_front();
            if ({bus.evt_code, bus.evt_ext, bus.evt_break} !== exp_e) begin
               n_bad++;
               $display("FAIL event: got %0h/%0b/%0b expected %0h/%0b/%0b",
                        bus.evt_code, bus.evt_ext, bus.evt_break, exp_e[9:2], exp_e[1], exp_e[0]);
            end
         end
      end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      bus.byte_err   = 1'b0;
      bus.evt_ready  = 1'b0;
      idle(2);
      check_reset("reset");
      reset = 1'b0;
      // make/break of A
      bus.evt_ready = 1'b1;
      expect_evt(8'h1C, 0, 0);
      send(8'h1C);
      chk("held A make", 32'(bus.held), 32'h02);
      send(8'hF0);
      expect_evt(8'h1C, 0, 1);
      send(8'h1C);
      chk("held A break", 32'(bus.held), 32'h00);
      // extended up arrow, then keypad 8
      send(8'hE0);
      expect_evt(8'h75, 1, 0);
      send(8'h75);
      chk("held up make", 32'(bus.held), 32'h10);
      send(8'hE0);
      send(8'hF0);
      expect_evt(8'h75, 1, 1);
      send(8'h75);
      chk("held up break", 32'(bus.held), 32'h00);
      expect_evt(8'h75, 0, 0);
      send(8'h75);
      chk("held kp8", 32'(bus.held), 32'h00);
      // filtering and error recovery
      send(8'hAA);
      send(8'hFA);
      send(8'hE0);
      send(8'h74, 1'b1);
      expect_evt(8'h23, 0, 0);
      send(8'h23);
      chk("err_count", 32'(bus.err_count), 1);
      chk("held D make", 32'(bus.held), 32'h08);
      send(8'hF0);
      expect_evt(8'h23, 0, 1);
      send(8'h23);
      idle(4);
      chk("drain 1", 32'(exp_q.size()), 0);
      // overflow: six makes into a four-entry FIFO
      bus.evt_ready = 1'b0;
      expect_evt(8'h15, 0, 0);
      send(8'h15);
      chk("latency valid", 32'(bus.evt_valid), 1);
      chk("latency code", 32'(bus.evt_code), 32'h15);
      expect_evt(8'h1D, 0, 0);
      send(8'h1D);
      expect_evt(8'h24, 0, 0);
      send(8'h24);
      expect_evt(8'h2D, 0, 0);
      send(8'h2D);
      chk("overflow before", 32'(bus.overflow), 0);
      send(8'h2C);
      send(8'h35);
      chk("overflow set", 32'(bus.overflow), 1);
      chk("held W", 32'(bus.held), 32'h01);
      n_pops = 0;
      bus.evt_ready = 1'b1;
      idle(8);
      chk("overflow pops", 32'(n_pops), 4);
      chk("empty after drain", 32'(bus.evt_valid), 0);
      chk("overflow sticky", 32'(bus.overflow), 1);
      // full FIFO with pop and push in the same cycle
      reset = 1'b1;
      bus.evt_ready = 1'b0;
      idle(1);
      check_reset("reset2");
      reset = 1'b0;
      expect_evt(8'h16, 0, 0);
      send(8'h16);
      expect_evt(8'h1E, 0, 0);
      send(8'h1E);
      expect_evt(8'h26, 0, 0);
      send(8'h26);
      expect_evt(8'h25, 0, 0);
      send(8'h25);
      bus.evt_ready = 1'b1;
      expect_evt(8'h2E, 0, 0);
      send(8'h2E);
      chk("push+pop overflow", 32'(bus.overflow), 0);
      idle(8);
      chk("drain 2", 32'(exp_q.size()), 0);
      // reset in the middle of E0 F0
      send(8'hE0);
      send(8'hF0);
      reset = 1'b1;
      idle(1);
      check_reset("reset3");
      reset = 1'b0;
      expect_evt(8'h6B, 0, 0);
      send(8'h6B);
      chk("held after 6B", 32'(bus.held), 32'h00);
      idle(4);
      chk("drain 3", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
